rtc_shadow_regbank: RTL and testbench

Parametrised double-buffered register bank between the bus-side register interface and the RTC datapath. Bus writes land in a staging bank and are tracked with per-entry dirty bits. When the transaction window closes, only dirty entries are committed to the active bank, one per cycle, and completion is signalled. Reads always return the active bank, and two status entries mirror the interrupt line.

---
 rtl/rtc_regbank_pkg.sv | 21 ++
 rtl/rtc_shadow_regbank.sv | 115 +++++++++++
 tb/tb_rtc_shadow_regbank.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_regbank_pkg.sv
// rtl/rtc_regbank_pkg.sv - shared constants for the RTC shadow register bank
// State codes, default status-pair location and status bit encoders.
package rtc_regbank_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OPEN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int DEF_STAT_ADDR = 10;

  // The low status entry reports "no interrupt", the high one the raw level.
  function automatic logic stat_lo_bit(input logic irq);
    return ~irq;
  endfunction

  function automatic logic stat_hi_bit(input logic irq);
    return irq;
  endfunction

endpackage

// File: rtl/rtc_shadow_regbank.sv
// rtl/rtc_shadow_regbank.sv - double-buffered register bank with dirty-only commit
// Bus writes stage with dirty tracking; closing the window copies dirty entries in index order.
module rtc_shadow_regbank
  import rtc_regbank_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int STAT_ADDR = DEF_STAT_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             txn,
  input  logic             abort,
  input  logic             irq,
  output logic             busy,
  output logic             commit_done
);

  localparam logic [AW-1:0] STAT_LO  = AW'(STAT_ADDR);
  localparam logic [AW-1:0] STAT_HI  = AW'(STAT_ADDR + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [DEPTH-1:0] dirty_q, dirty_d;
  logic [WIDTH-1:0] staging_q [DEPTH];
  logic [WIDTH-1:0] staging_d [DEPTH];
  logic [WIDTH-1:0] active_q  [DEPTH];
  logic [WIDTH-1:0] active_d  [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_hit;

  assign wr_ready    = (state_q == ST_IDLE) || (state_q == ST_OPEN);
  assign busy        = (state_q == ST_COMMIT) || (state_q == ST_DONE);
  assign commit_done = (state_q == ST_DONE);
  assign rd_data     = rd_data_q;

  // Status entries are hardware-owned, so bus writes to them never stage.
  assign wr_hit = wr_en && wr_ready && (wr_addr != STAT_LO) && (wr_addr != STAT_HI);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dirty_d   = dirty_q;
    staging_d = staging_q;
    active_d  = active_q;
    rd_data_d = active_q[rd_addr];

    if (wr_hit) begin
      staging_d[wr_addr] = wr_data;
      dirty_d[wr_addr]   = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (txn) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        if (abort) begin
          dirty_d = '0;
          state_d = ST_IDLE;
        end else if (!txn) begin
          idx_d   = '0;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (dirty_q[idx_q]) begin
          active_d[idx_q] = staging_q[idx_q];
          dirty_d[idx_q]  = 1'b0;
        end
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Applied last so the irq mirror always wins over any commit copy.
    active_d[STAT_LO] = WIDTH'(stat_lo_bit(irq));
    active_d[STAT_HI] = WIDTH'(stat_hi_bit(irq));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      dirty_q   <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        staging_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dirty_q   <= dirty_d;
      rd_data_q <= rd_data_d;
      staging_q <= staging_d;
      active_q  <= active_d;
    end
  end

endmodule

// File: tb/tb_rtc_shadow_regbank.sv
// tb/tb_rtc_shadow_regbank.sv - self-checking bench for rtc_shadow_regbank
// Array-level reference model of staging, dirty set and active bank; randomized windows.
module tb_rtc_shadow_regbank;

  localparam int DEPTH = 16;
  localparam int STAT  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       txn = 1'b0;
  logic       abort = 1'b0;
  logic       irq = 1'b0;
  logic       busy;
  logic       commit_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_stage  [DEPTH];
  logic [7:0] m_active [DEPTH];
  bit         m_dirty  [DEPTH];

  rtc_shadow_regbank #(.WIDTH(8), .DEPTH(16), .STAT_ADDR(10)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data), .txn(txn),
    .abort(abort), .irq(irq), .busy(busy), .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_stage[i] = 8'h00; m_active[i] = 8'h00; m_dirty[i] = 1'b0;
    end
  endfunction

  function automatic void model_write(input int a, input logic [7:0] d);
    if (a != STAT && a != STAT + 1) begin
      m_stage[a] = d;
      m_dirty[a] = 1'b1;
    end
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < DEPTH; i++)
      if (m_dirty[i]) begin
        m_active[i] = m_stage[i];
        m_dirty[i]  = 1'b0;
      end
  endfunction

  function automatic void model_abort();
    for (int i = 0; i < DEPTH; i++) m_dirty[i] = 1'b0;
  endfunction

  function automatic logic [7:0] exp_rd(input int a);
    if (a == STAT) return {7'b0, ~irq};
    if (a == STAT + 1) return {7'b0, irq};
    return m_active[a];
  endfunction

  task automatic rd(input int a, output logic [7:0] v);
    rd_addr = 4'(a);
    tick();
    v = rd_data;
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    model_write(a, d);
  endtask

  task automatic open_win();
    txn = 1'b1;
    tick();
  endtask

  // Called just after the edge that sampled txn=0; returns edges until commit_done is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (commit_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (rd_data !== 8'h00 || wr_ready !== 1'b1 || busy !== 1'b0 || commit_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%h rdy=%b busy=%b done=%b exp 00 1 0 0",
               rd_data, wr_ready, busy, commit_done);
    end
    reset = 1'b0;
    model_reset();
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      rd(a, v);
      checks++;
      if (v !== exp_rd(a)) begin
        errors++;
        $display("FAIL reset_read@%0d: got %h exp %h", a, v, exp_rd(a));
      end
    end
  endtask

  task automatic test_basic_commit();
    int n;
    logic [7:0] v;
    open_win();
    do_write(0, 8'h59);
    do_write(2, 8'h23);
    rd_addr = 4'd0;
    txn = 1'b0;
    tick();
    tick();
    checks++;
    if (rd_data !== 8'h00) begin
      errors++; $display("FAIL basic_pre_copy: got %h exp 00", rd_data);
    end
    tick();
    checks++;
    if (rd_data !== 8'h59) begin
      errors++; $display("FAIL basic_post_copy: got %h exp 59", rd_data);
    end
    wait_done(n);
    checks++;
    if (n + 2 + 1 != DEPTH + 1) begin
      errors++; $display("FAIL basic_done_cycle: got %0d exp %0d", n + 3, DEPTH + 1);
    end
    tick();
    checks++;
    if (commit_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: done=%b busy=%b exp 0 0", commit_done, busy);
    end
    model_commit();
    rd(2, v);
    checks++;
    if (v !== exp_rd(2) || v !== 8'h23) begin
      errors++; $display("FAIL basic_rd2: got %h exp 23", v);
    end
  endtask

  task automatic test_dirty_only();
    int n;
    logic [7:0] v;
    for (int w = 0; w < 2; w++) begin
      open_win();
      if (w == 0) do_write(5, 8'h11);
      else        do_write(6, 8'h22);
      txn = 1'b0;
      tick();
      wait_done(n);
      checks++;
      if (n != DEPTH) begin
        errors++; $display("FAIL dirty_latency: got %0d exp %0d", n, DEPTH);
      end
      tick();
      model_commit();
    end
    rd(5, v);
    checks++;
    if (v !== 8'h11 || v !== exp_rd(5)) begin
      errors++; $display("FAIL dirty_keep5: got %h exp 11", v);
    end
    rd(6, v);
    checks++;
    if (v !== 8'h22 || v !== exp_rd(6)) begin
      errors++; $display("FAIL dirty_new6: got %h exp 22", v);
    end
  endtask

  task automatic test_abort();
    int n;
    int pulses;
    logic [7:0] v;
    open_win();
    do_write(3, 8'h77);
    abort = 1'b1; txn = 1'b0;
    tick();
    abort = 1'b0;
    model_abort();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (commit_done === 1'b1 || busy === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL abort_no_commit: got %0d busy/done cycles exp 0", pulses);
    end
    open_win();
    txn = 1'b0;
    tick();
    wait_done(n);
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL abort_empty_latency: got %0d exp %0d", n, DEPTH);
    end
    tick();
    model_commit();
    rd(3, v);
    checks++;
    if (v !== 8'h00 || v !== exp_rd(3)) begin
      errors++; $display("FAIL abort_addr3: got %h exp 00", v);
    end
  endtask

  task automatic test_status_pair();
    int n;
    logic [7:0] v;
    irq = 1'b1;
    tick();
    rd(STAT, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL stat_lo_irq1: got %h exp 00", v); end
    rd(STAT + 1, v);
    checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL stat_hi_irq1: got %h exp 01", v); end
    open_win();
    do_write(STAT, 8'hFF);
    txn = 1'b0;
    tick();
    wait_done(n);
    tick();
    model_commit();
    rd(STAT, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL stat_write_ignored: got %h exp 00", v); end
    rd_addr = 4'(STAT);
    irq = 1'b0;
    tick();
    tick();
    checks++;
    if (rd_data !== 8'h01) begin errors++; $display("FAIL stat_toggle_idle: got %h exp 01", rd_data); end
    open_win();
    txn = 1'b0;
    tick();
    tick(); tick(); tick();
    irq = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || rd_data !== 8'h00) begin
      errors++; $display("FAIL stat_toggle_commit: busy=%b rd=%h exp 1 00", busy, rd_data);
    end
    wait_done(n);
    tick();
    model_commit();
  endtask

  task automatic test_dropped_late_txn();
    int n;
    logic [7:0] v;
    open_win();
    txn = 1'b0;
    tick();
    txn = 1'b1;
    tick();
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'hAA;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL drop_wr_ready: got %b exp 0", wr_ready); end
    tick();
    wr_en = 1'b0;
    wait_done(n);
    checks++;
    if (n != DEPTH - 2) begin errors++; $display("FAIL drop_latency: got %0d exp %0d", n, DEPTH - 2); end
    model_commit();
    tick();
    checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL late_txn_idle: busy=%b rdy=%b exp 0 1", busy, wr_ready);
    end
    tick();
    do_write(4, 8'h3C);
    txn = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL late_txn_window: busy=%b exp 1", busy); end
    wait_done(n);
    tick();
    model_commit();
    rd(1, v);
    checks++;
    if (v !== exp_rd(1)) begin errors++; $display("FAIL drop_addr1: got %h exp %h", v, exp_rd(1)); end
    rd(4, v);
    checks++;
    if (v !== 8'h3C || v !== exp_rd(4)) begin errors++; $display("FAIL late_txn_commit4: got %h exp 3c", v); end
  endtask

  task automatic test_random();
    int n;
    int nw;
    int a;
    logic [7:0] d;
    logic [7:0] v;
    for (int w = 0; w < 6; w++) begin
      open_win();
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) begin
        a = $urandom_range(0, DEPTH - 1);
        d = 8'($urandom_range(0, 255));
        do_write(a, d);
      end
      if ($urandom_range(0, 3) == 0) begin
        abort = 1'b1; txn = 1'b0;
        tick();
        abort = 1'b0;
        model_abort();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rand_abort_busy: got %b exp 0", busy); end
      end else begin
        txn = 1'b0;
        a = $urandom_range(0, DEPTH - 1);
        d = 8'($urandom_range(0, 255));
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        model_write(a, d);
        wait_done(n);
        checks++;
        if (n != DEPTH) begin errors++; $display("FAIL rand_latency: got %0d exp %0d", n, DEPTH); end
        tick();
        model_commit();
      end
      for (int i = 0; i < DEPTH; i++) begin
        rd(i, v);
        checks++;
        if (v !== exp_rd(i)) begin
          errors++; $display("FAIL rand_read w%0d @%0d: got %h exp %h", w, i, v, exp_rd(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_commit();
    int n;
    int bad;
    logic [7:0] v;
    open_win();
    do_write(12, 8'h33);
    txn = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    checks++;
    if (busy !== 1'b0 || commit_done !== 1'b0 || wr_ready !== 1'b1 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b done=%b rdy=%b rd=%h exp 0 0 1 00",
               busy, commit_done, wr_ready, rd_data);
    end
    bad = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1 || commit_done === 1'b1) bad++;
      tick();
      n++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_no_done: got %0d cycles exp 0", bad); end
    for (int a = 0; a < DEPTH; a++) begin
      rd(a, v);
      checks++;
      if (v !== exp_rd(a)) begin
        errors++; $display("FAIL midreset_read@%0d: got %h exp %h", a, v, exp_rd(a));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_dirty_only();
    test_abort();
    test_status_pair();
    test_dropped_late_txn();
    test_random();
    test_reset_mid_commit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
